// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe elastic pipeline.
package dff_pipe_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 3;

    // Bits needed to count 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Producer-side and consumer-side valid/ready channels of dff_pipe.
interface dff_pipe_if
    import dff_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/dff_pipe_stage.sv
// One elastic register stage: loads from upstream whenever it is empty or
// its downstream neighbour is also advancing.
module dff_pipe_stage
    import dff_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             rdy
);

    logic             r_v;
    logic [WIDTH-1:0] r_d;

    assign rdy = ~r_v | dn_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= 1'b0;
            r_d <= RST_VAL;
        end else if (flush) begin
            r_v <= 1'b0;
        end else if (rdy) begin
            r_v <= up_valid;
            // Bubbles advance the valid bit only; data keeps its last beat.
            if (up_valid) begin
                r_d <= up_data;
            end
        end
    end

    assign v = r_v;
    assign d = r_d;

endmodule

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage retiming pipeline with valid/ready backpressure,
// synchronous flush and a registered occupancy count.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH   = DEF_WIDTH,
    parameter int unsigned      DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    dff_pipe_if.slave                 bus,
    output logic [cnt_w(DEPTH)-1:0]   occupancy
);

    localparam int unsigned OCC_W = cnt_w(DEPTH);

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [OCC_W-1:0] r_occ;

    // Per-stage signals live inside each generate block so the ready chain
    // is a string of distinct nets rather than one self-referencing vector.
    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             w_v;
        logic             w_rdy;
        logic [WIDTH-1:0] w_d;
        logic             w_up_valid;
        logic [WIDTH-1:0] w_up_data;
        logic             w_dn_ready;

        if (gi == 0) begin : g_head
            assign w_up_valid = bus.in_valid;
            assign w_up_data  = bus.in_data;
        end else begin : g_body
            assign w_up_valid = g_stage[gi-1].w_v;
            assign w_up_data  = g_stage[gi-1].w_d;
        end

        if (gi == DEPTH - 1) begin : g_tail
            assign w_dn_ready = bus.out_ready;
        end else begin : g_mid
            assign w_dn_ready = g_stage[gi+1].w_rdy;
        end

        dff_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_valid (w_up_valid),
            .up_data  (w_up_data),
            .dn_ready (w_dn_ready),
            .v        (w_v),
            .d        (w_d),
            .rdy      (w_rdy)
        );
    end

    assign bus.in_ready  = g_stage[0].w_rdy & ~flush;
    assign bus.out_valid = g_stage[DEPTH-1].w_v;
    assign bus.out_data  = g_stage[DEPTH-1].w_d;

    assign w_in_xfer  = bus.in_valid & bus.in_ready;
    assign w_out_xfer = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_in_xfer) - OCC_W'(w_out_xfer);
        end
    end

    assign occupancy = r_occ;

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a beat-position model.
module tb_dff_pipe;
    import dff_pipe_pkg::*;

    localparam int unsigned      WIDTH   = 8;
    localparam int unsigned      DEPTH   = 3;
    localparam int               D       = DEPTH;
    localparam logic [WIDTH-1:0] RST_VAL = 8'hA5;
    localparam int unsigned      OCC_W   = cnt_w(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [OCC_W-1:0] occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    dff_pipe_if #(.WIDTH(WIDTH)) bus ();

    dff_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: an ordered list of beats in flight, each with its stage position.
    // The oldest beat leaves from the last position when the consumer is ready;
    // every other beat moves forward one slot unless the slot ahead stays taken.
    typedef struct {
        logic [WIDTH-1:0] data;
        int               pos;
    } beat_t;

    beat_t            mq[$];
    logic [WIDTH-1:0] m_last;
    bit               m_known = 1'b0;

    initial begin : model
        int np[$];
        int bound;
        bit m_rdy;
        bit m_ov;
        forever begin
            @(negedge clk);
            bound = bus.out_ready ? D : D - 1;
            np.delete();
            for (int k = 0; k < mq.size(); k++) begin
                if (mq[k].pos + 1 <= bound) np.push_back(mq[k].pos + 1);
                else                        np.push_back(mq[k].pos);
                bound = np[k] - 1;
            end
            m_rdy = !flush && (bound >= 0);
            m_ov  = (mq.size() > 0) && (mq[0].pos == D - 1);
            if (m_known) begin
                check("m_out_valid", bus.out_valid, m_ov);
                check("m_out_data",  bus.out_data,  m_last);
                check("m_in_ready",  bus.in_ready,  m_rdy);
                check("m_occupancy", occupancy,     mq.size());
            end
            if (rst) begin
                mq.delete();
                m_last  = RST_VAL;
                m_known = 1'b1;
            end else if (flush) begin
                mq.delete();
            end else begin
                for (int k = 0; k < np.size(); k++) begin
                    if (np[k] == D - 1 && mq[k].pos != D - 1) m_last = mq[k].data;
                    mq[k].pos = np[k];
                end
                if (mq.size() > 0 && mq[0].pos == D) void'(mq.pop_front());
                if (bus.in_valid && m_rdy) begin
                    mq.push_back('{bus.in_data, 0});
                    if (D == 1) m_last = bus.in_data;
                end
            end
        end
    end

    logic [WIDTH-1:0] got[8];
    int               n_got;
    int               n_seen;

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data,  8'hA5);
        check("rst_occ",       occupancy,     0);
        check("rst_in_ready",  bus.in_ready,  1);

        // Streaming 01..0A with no stalls
        bus.out_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            bus.in_valid = (j < 10);
            bus.in_data  = WIDTH'(j + 1);
            tick();
            if (j >= 2) begin
                check("stream_valid", bus.out_valid, 1);
                check("stream_data",  bus.out_data,  j - 1);
            end
            if (j >= 2 && j <= 9) check("stream_occ", occupancy, 3);
        end
        bus.in_valid = 1'b0;
        repeat (4) tick();
        check("stream_drain_occ", occupancy, 0);

        // Backpressure: fourth beat held off until the consumer drains
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = WIDTH'(8'h11 * (k + 1));
            #1;
            check("bp_in_ready", bus.in_ready, (k < 3));
            if (k < 3) tick();
        end
        tick();
        tick();
        check("bp_occ",  occupancy,    3);
        check("bp_held", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        n_got = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus.out_valid && n_got < 8) begin
                got[n_got] = bus.out_data;
                n_got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                tick();
                bus.in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        check("bp_count", n_got, 4);
        for (int k = 0; k < 4; k++) check("bp_order", got[k], 8'h11 * (k + 1));

        // Full with simultaneous drain
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = WIDTH'(8'h10 * (k + 1));
            tick();
        end
        bus.in_data   = 8'h40;
        bus.out_ready = 1'b1;
        #1;
        check("fd_in_ready",  bus.in_ready, 1);
        check("fd_out_data",  bus.out_data, 8'h10);
        check("fd_occ_pre",   occupancy,    3);
        tick();
        bus.in_valid = 1'b0;
        check("fd_occ",       occupancy,    3);
        check("fd_out_data2", bus.out_data, 8'h20);
        repeat (4) tick();
        check("fd_drain_occ", occupancy,    0);
        check("fd_last_data", bus.out_data, 8'h40);

        // Flush with two beats in flight
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hC1;
        tick();
        bus.in_data   = 8'hC2;
        tick();
        bus.in_data   = 8'hEE;
        flush         = 1'b1;
        #1;
        check("fl_in_ready", bus.in_ready, 0);
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_out_valid", bus.out_valid, 0);
        check("fl_occ",       occupancy,     0);
        check("fl_data_hold", bus.out_data,  8'h40);
        bus.out_ready = 1'b1;
        n_seen = 0;
        repeat (5) begin
            tick();
            if (bus.out_valid) n_seen++;
        end
        check("fl_no_emerge",  n_seen,       0);
        check("fl_data_hold2", bus.out_data, 8'h40);

        // Mid-operation reset, then clean restart
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h51;
        tick();
        bus.in_data  = 8'h52;
        tick();
        check("mr_occ", occupancy, 2);
        bus.in_data = 8'h53;
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("mr_out_valid", bus.out_valid, 0);
        check("mr_out_data",  bus.out_data,  8'hA5);
        check("mr_occ0",      occupancy,     0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h61;
        tick();
        bus.in_valid = 1'b0;
        check("mr_lat1", bus.out_valid, 0);
        tick();
        check("mr_lat2", bus.out_valid, 0);
        tick();
        check("mr_lat3_valid", bus.out_valid, 1);
        check("mr_lat3_data",  bus.out_data,  8'h61);

        // Randomized traffic with varying consumer stall rates
        for (int blk = 0; blk < 6; blk++) begin
            repeat (500) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.in_data   = WIDTH'($urandom);
                bus.out_ready = ($urandom_range(0, 3) < (blk % 3) + 1);
                flush         = ($urandom_range(0, 49) == 0);
                rst           = ($urandom_range(0, 199) == 0);
                tick();
            end
        end
        flush        = 1'b0;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
